sar_conv_sequencer: RTL and testbench
=====================================

Name: sar_conv_sequencer

Overview:
- Scheduler placed in front of the 12-bit SAR conversion logic.
- Scans the enabled analog channels round-robin. For each channel it drives the input-mux select, times the sample/settle window, then pulses a start to the SAR logic.
- Waits for conv_done, captures the SAR result word and presents it with a channel tag on a valid/ready output port.
- Also covers conversions that never complete (timeout) and backpressure from the result consumer.

Parameters:
- RES, 12, SAR result width in bits.
- NCH, 4, number of analog channels; ≥2, power of two.
- CW, 2, channel index width = log2(NCH).
- SETTLE_CYC, 4, sample/settle cycles after a mux change; ≥1.
- TIMEOUT_CYC, 63, max cycles from sar_start to conv_done before abort; ≥RES+2.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  scan enable; level.
- ch_mask  in  NCH  per-channel enable; bit i=1 means channel i is scanned.
- mux_sel  out  CW  analog mux channel select.
- sample_en  out  1  high during the settle/sample window.
- sar_start  out  1  one-cycle start pulse to the SAR logic.
- sar_conv_done  in  1  SAR end-of-conversion; single-cycle or level.
- sar_bitout  in  RES  SAR result; valid in the cycle sar_conv_done is high.
- res_data  out  RES  result word.
- res_ch  out  CW  channel of res_data.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts; transfer happens when res_valid & res_ready.
- busy  out  1  FSM not in IDLE.
- timeout_err  out  1  sticky: a conversion timed out.

Behaviour:
- Reset (async):
  - state=IDLE, mux_sel=0, sample_en=0, sar_start=0.
  - res_data=0, res_ch=0, res_valid=0, busy=0, timeout_err=0.
  - Round-robin pointer=NCH-1, so the first pick is channel 0.
- States: IDLE, SELECT, SETTLE, START, WAIT, STORE.
- IDLE:
  - Leave when en=1 and ch_mask≠0; go to SELECT.
  - Stay in IDLE otherwise.
- SELECT (1 cycle):
  - Pick the lowest enabled channel strictly after the pointer, wrapping modulo NCH. A single enabled channel is picked repeatedly.
  - Register it into mux_sel and the pointer; load the settle counter; go to SETTLE.
- SETTLE:
  - sample_en=1 for exactly SETTLE_CYC cycles, then go to START.
- START:
  - sar_start=1 for exactly one cycle; clear the timeout counter; go to WAIT.
  - mux_sel is held constant from SELECT until leaving WAIT.
- WAIT:
  - When sar_conv_done=1, capture sar_bitout into the internal result and go to STORE.
  - If the counter reaches TIMEOUT_CYC without conv_done: set timeout_err, discard the conversion, go to SELECT or IDLE (same rule as after STORE).
  - sar_conv_done is ignored in every state other than WAIT.
- STORE:
  - If res_valid=0, or res_valid & res_ready in the same cycle: load res_data/res_ch, set res_valid=1, then apply the next-step rule below.
  - Otherwise stall in STORE. No results are dropped; the scan stalls instead.
- Next step after STORE or a timeout: go to SELECT if en=1 and ch_mask≠0, else IDLE.
- Output handshake:
  - res_valid clears on res_valid & res_ready unless a new result is loaded in the same cycle.
  - res_data and res_ch are stable while res_valid=1 and res_ready=0.
- Mode changes mid-scan:
  - en deasserted mid-scan: the current conversion completes and is delivered, then the FSM goes to IDLE.
  - ch_mask changes are sampled only in SELECT and at the next-step decision.
  - ch_mask becoming 0 mid-scan is handled the same as en=0.
- Latency: SELECT to res_valid = 1 + SETTLE_CYC + 1 + Tconv + 1 cycles, where Tconv is start-to-done.
- timeout_err clears only on reset.
- busy = (state≠IDLE).

Optional Feature:
- Macro: SAR_SEQ_AVG4_EN.
- Defined:
  - Each selected channel is converted 4 times back-to-back: SETTLE once, then START/WAIT ×4.
  - The four results are summed in an RES+2-bit accumulator; res_data = sum[RES+1:2], i.e. the truncated mean.
  - A timeout in any of the four discards the whole channel result.
- Undefined: one conversion per channel; res_data = captured sar_bitout.

Test Plan:
- Scan order: reset, ch_mask=4'b1011, en=1, SAR model done 14 cycles after start, res_ready=1 → results on channels 0,1,3,0,… in order; sample_en high exactly 4 cycles before each sar_start; sar_start width 1.
- Data capture: SAR model returns 12'hA5C on ch1 only → res_data=12'hA5C, res_ch=1; other channels carry their model values.
- Backpressure: res_ready=0 for 100 cycles → first result held stable with res_valid=1, FSM stalls in STORE, no further sar_start. Then res_ready=1 → each held result delivered once, in order, none lost.
- Timeout: SAR model never asserts done on ch2 → timeout_err=1 exactly 63 cycles after sar_start; no result for ch2; scan continues with ch3.
- Disable/reset mid-op: en=0 during WAIT → that result is delivered, then busy=0. Async reset asserted during SETTLE → all outputs return to reset values without waiting for a clock edge.
- SAR_SEQ_AVG4_EN: model returns 100,101,102,104 → res_data=101 (sum 407>>2); four sar_start pulses per res_valid.

Source files
------------

// File: rtl/sar_conv_sequencer.sv
// Round-robin scan scheduler in front of a SAR conversion core.
// Optional SAR_SEQ_AVG4_EN: four conversions per channel, truncated mean reported.
module sar_conv_sequencer #(
    parameter int RES         = 12,
    parameter int NCH         = 4,
    parameter int CW          = 2,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 63
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic [NCH-1:0] ch_mask,
    output logic [CW-1:0]  mux_sel,
    output logic           sample_en,
    output logic           sar_start,
    input  logic           sar_conv_done,
    input  logic [RES-1:0] sar_bitout,
    output logic [RES-1:0] res_data,
    output logic [CW-1:0]  res_ch,
    output logic           res_valid,
    input  logic           res_ready,
    output logic           busy,
    output logic           timeout_err
);

`ifdef SAR_SEQ_AVG4_EN
    localparam int AW = RES + 2;
`else
    localparam int AW = RES;
`endif
    localparam int SCW = $clog2(SETTLE_CYC + 1);
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, SELECT, SETTLE, START, WAIT, STORE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]  ptr;
    logic [CW-1:0]  pick;
    logic           pick_ok;
    logic [SCW-1:0] settle_cnt;
    logic [TCW-1:0] tmo_cnt;
    logic [AW-1:0]  acc;
    logic           scan_on;
    logic           settle_last;
    logic           conv_hit;
    logic           tmo_hit;
    logic           res_load;
    logic           last_conv;
`ifdef SAR_SEQ_AVG4_EN
    logic [1:0]     conv_idx;

    assign last_conv = (conv_idx == 2'd3);
`else
    assign last_conv = 1'b1;
`endif

    assign scan_on     = en && (ch_mask != '0);
    assign settle_last = (settle_cnt == SCW'(SETTLE_CYC - 1));
    assign conv_hit    = (state == WAIT) && sar_conv_done;
    assign tmo_hit     = (state == WAIT) && !sar_conv_done && (tmo_cnt == TCW'(TIMEOUT_CYC - 2));

    // Result port: a word transfers on any rising edge where res_valid && res_ready.
    // A new word may load in the same cycle the previous one transfers; while
    // res_valid is high and res_ready low, res_data/res_ch hold and the scan stalls.
    assign res_load = (state == STORE) && (!res_valid || res_ready);

    // Lowest enabled channel strictly after ptr; descending loop lets the nearest win.
    always_comb begin
        pick    = ptr;
        pick_ok = 1'b0;
        for (int i = NCH; i >= 1; i--) begin
            if (ch_mask[ptr + CW'(i)]) begin
                pick    = ptr + CW'(i);
                pick_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sample_en = 1'b0;
        sar_start = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE:   if (scan_on) state_nxt = SELECT;
            SELECT: state_nxt = pick_ok ? SETTLE : IDLE;
            SETTLE: begin
                sample_en = 1'b1;
                if (settle_last) state_nxt = START;
            end
            START: begin
                sar_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (conv_hit)     state_nxt = last_conv ? STORE : START;
                else if (tmo_hit) state_nxt = scan_on ? SELECT : IDLE;
            end
            STORE:  if (res_load) state_nxt = scan_on ? SELECT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr         <= CW'(NCH - 1);
            mux_sel     <= '0;
            settle_cnt  <= '0;
            tmo_cnt     <= '0;
            acc         <= '0;
            res_data    <= '0;
            res_ch      <= '0;
            res_valid   <= 1'b0;
            timeout_err <= 1'b0;
`ifdef SAR_SEQ_AVG4_EN
            conv_idx    <= '0;
`endif
        end else begin
            case (state)
                SELECT: begin
                    if (pick_ok) begin
                        mux_sel <= pick;
                        ptr     <= pick;
                    end
                    settle_cnt <= '0;
                    acc        <= '0;
`ifdef SAR_SEQ_AVG4_EN
                    conv_idx   <= '0;
`endif
                end
                SETTLE: settle_cnt <= settle_cnt + 1'b1;
                START:  tmo_cnt <= '0;
                WAIT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (sar_conv_done) begin
`ifdef SAR_SEQ_AVG4_EN
                        acc      <= acc + AW'(sar_bitout);
                        conv_idx <= conv_idx + 2'd1;
`else
                        acc      <= sar_bitout;
`endif
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                    end
                end
                default: ;
            endcase

            // Upper RES bits of the accumulator: the sample itself, or sum/4 when averaging.
            if (res_load) begin
                res_data  <= acc[AW-1 -: RES];
                res_ch    <= mux_sel;
                res_valid <= 1'b1;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Bench for sar_conv_sequencer: SAR core model, scan-order/result scoreboard, directed phases.
module tb_sar_conv_sequencer;
    localparam int RES = 12;
    localparam int NCH = 4;
    localparam int CW  = 2;
`ifdef SAR_SEQ_AVG4_EN
    localparam int NCONV = 4;
`else
    localparam int NCONV = 1;
`endif

    logic           clk;
    logic           rst;
    logic           en;
    logic [NCH-1:0] ch_mask;
    logic [CW-1:0]  mux_sel;
    logic           sample_en;
    logic           sar_start;
    logic           sar_conv_done;
    logic [RES-1:0] sar_bitout;
    logic [RES-1:0] res_data;
    logic [CW-1:0]  res_ch;
    logic           res_valid;
    logic           res_ready;
    logic           busy;
    logic           timeout_err;

    int n_pass  = 0;
    int n_total = 0;
    logic [CW+RES-1:0] exp_q[$];
    logic [RES-1:0]    base[NCH];
    bit                never_done[NCH];
    bit                fixed_lat;
    int                mptr;
    int                grp;
    int                sar_k;
    int                n_xfer;

    sar_conv_sequencer dut (
        .clk(clk), .reset(rst), .en(en), .ch_mask(ch_mask),
        .mux_sel(mux_sel), .sample_en(sample_en), .sar_start(sar_start),
        .sar_conv_done(sar_conv_done), .sar_bitout(sar_bitout),
        .res_data(res_data), .res_ch(res_ch), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int next_ch(input int p, input logic [NCH-1:0] m);
        for (int i = 1; i <= NCH; i++)
            if (m[(p + i) % NCH]) return (p + i) % NCH;
        return -1;
    endfunction

    function automatic logic [RES-1:0] offs(input int k);
        case (k)
            1:       return RES'(1);
            2:       return RES'(2);
            3:       return RES'(4);
            default: return RES'(0);
        endcase
    endfunction

    // SAR core model: answers each start after a latency; the expected word is the mean of the group.
    initial begin
        int             ch;
        int             lat;
        logic [RES-1:0] v;
        logic [RES+1:0] sum;
        logic [RES-1:0] mean;
        sar_conv_done = 1'b0;
        sar_bitout    = '0;
        sum           = '0;
        sar_k         = 0;
        forever begin
            @(posedge clk); #2;
            sar_conv_done = 1'b0;
            if (rst) begin
                sar_k = 0;
                sum   = '0;
            end else if (sar_start) begin
                ch = int'(mux_sel);
                if (!never_done[ch]) begin
                    lat = fixed_lat ? 14 : $urandom_range(1, 12);
                    repeat (lat) begin @(posedge clk); #2; end
                    v             = base[ch] + offs(sar_k);
                    sar_conv_done = 1'b1;
                    sar_bitout    = v;
                    sum           = sum + (RES+2)'(v);
                    if (sar_k == NCONV - 1) begin
                        mean = RES'(sum / NCONV);
                        exp_q.push_back({CW'(ch), mean});
                        sar_k = 0;
                        sum   = '0;
                    end else begin
                        sar_k++;
                    end
                end
            end
        end
    end

    // Monitor: settle window, start width, scan order and result scoreboard.
    initial begin
        logic [4:0] hist;
        logic       prev_start;
        int         e;
        hist = '0; prev_start = 1'b0; mptr = NCH - 1; grp = 0; n_xfer = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hist = '0;
                prev_start = 1'b0;
                continue;
            end
            if (prev_start) check("sar_start_width", sar_start, 0);
            if (sar_start) begin
                check("sample_en_at_start", sample_en, 0);
                if (grp == 0) begin
                    check("settle_window", hist, 5'b01111);
                    e = next_ch(mptr, ch_mask);
                    check("scan_order", mux_sel, e);
                    if (e >= 0) begin
                        mptr = e;
                        if (!never_done[e]) grp = (grp + 1) % NCONV;
                    end
                end else begin
                    check("avg_no_resettle", hist[0], 0);
                    check("avg_same_channel", mux_sel, mptr);
                    grp = (grp + 1) % NCONV;
                end
            end
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", res_valid, 0);
                end else begin
                    check("res_word", {res_ch, res_data}, exp_q[0]);
                    if (res_ready) begin
                        void'(exp_q.pop_front());
                        n_xfer++;
                    end
                end
            end
            hist       = {hist[3:0], sample_en};
            prev_start = sar_start;
        end
    end

    task automatic wait_for(input string tag, input int kind, input int limit);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(posedge clk); #2;
            case (kind)
                0:       seen = !busy;
                1:       seen = sample_en;
                2:       seen = sar_start;
                3:       seen = sar_start && (mux_sel == 2'd2);
                default: seen = 1'b1;
            endcase
        end
        check(tag, seen, 1);
    endtask

    task automatic wait_xfer(input string tag, input int n, input int limit);
        int target;
        target = n_xfer + n;
        for (int i = 0; i < limit && n_xfer < target; i++) begin
            @(posedge clk); #2;
        end
        check(tag, n_xfer >= target, 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_mux_sel", mux_sel, 0);
        check("rst_sample_en", sample_en, 0);
        check("rst_sar_start", sar_start, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_ch", res_ch, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);
    endtask

    initial begin
        int n_st;
        rst = 1'b1; en = 1'b0; ch_mask = '0; res_ready = 1'b1; fixed_lat = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            base[c]       = RES'($urandom_range(0, 4091));
            never_done[c] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs();
        rst = 1'b0;
        repeat (4) begin @(posedge clk); #2; end
        check("idle_without_en", busy, 0);

        // Scan order with mask 1011, fixed 14-cycle conversions, consumer always ready.
        ch_mask = 4'b1011;
        en      = 1'b1;
        wait_xfer("scan_results", 6, 400);

        // Data capture with distinctive values and a randomly stalling consumer.
        base[1]   = 12'hA5C;
        base[0]   = 12'd100;
        fixed_lat = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            res_ready = 1'($urandom_range(0, 1));
        end
        res_ready = 1'b1;

        // Backpressure: hold res_ready low, scan must stall in STORE.
        wait_for("bp_sync", 2, 200);
        res_ready = 1'b0;
        n_st = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (i >= 160 && sar_start) n_st++;
        end
        check("bp_no_start", n_st, 0);
        check("bp_valid_held", res_valid, 1);
        check("bp_busy", busy, 1);
        check("bp_pending", exp_q.size(), 2);
        res_ready = 1'b1;
        wait_xfer("bp_drain", 2, 10);

        // Timeout on channel 2.
        en = 1'b0;
        wait_for("to_idle", 0, 300);
        ch_mask       = 4'b1111;
        never_done[2] = 1'b1;
        en            = 1'b1;
        wait_for("to_start_ch2", 3, 300);
        repeat (62) begin @(posedge clk); #2; end
        check("timeout_err_early", timeout_err, 0);
        @(posedge clk); #2;
        check("timeout_err_set", timeout_err, 1);
        wait_for("to_next_start", 2, 50);
        check("to_next_is_ch3", mux_sel, 3);
        never_done[2] = 1'b0;

        // en dropped during WAIT: result still delivered, then idle.
        wait_for("en_drop_start", 2, 200);
        @(posedge clk); #2;
        en = 1'b0;
        wait_for("en_drop_idle", 0, 300);
        repeat (2) begin @(posedge clk); #2; end
        check("en_drop_delivered", exp_q.size(), 0);
        check("en_drop_no_valid", res_valid, 0);
        check("en_drop_busy", busy, 0);

        // Asynchronous reset in the middle of SETTLE.
        en = 1'b1;
        wait_for("rst_settle", 1, 100);
        #1 rst = 1'b1;
        #1;
        check_reset_outputs();
        exp_q.delete();
        mptr = NCH - 1;
        grp  = 0;
        @(posedge clk); #2;
        rst = 1'b0;
        wait_for("post_rst_start", 2, 50);
        check("post_rst_first_ch", mux_sel, 0);
        wait_xfer("post_rst_results", 4, 600);

        en = 1'b0;
        wait_for("final_idle", 0, 400);
        repeat (3) begin @(posedge clk); #2; end
        check("final_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
